traffic_junction_ctrl: RTL

TRAFFIC_JUNCTION_CTRL -- requirements
Module: traffic_junction_ctrl

---
 rtl/traffic_junction_ctrl.sv | 122 ++++++++++++
 1 files changed

// File: rtl/traffic_junction_ctrl.sv
// Two-road junction controller with pedestrian phase.
// A dwell counter times each phase, and the lamp outputs are registered.
module traffic_junction_ctrl #(
    parameter int unsigned MIN_GREEN  = 8,
    parameter int unsigned SIDE_GREEN = 6,
    parameter int unsigned YELLOW_T   = 3,
    parameter int unsigned ALLRED_T   = 1,
    parameter int unsigned WALK_T     = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       side_req,
    input  logic       ped_req,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic       walk,
    output logic [2:0] phase
);

    localparam logic [2:0] LampRed    = 3'b001;
    localparam logic [2:0] LampGreen  = 3'b010;
    localparam logic [2:0] LampYellow = 3'b100;

    localparam logic [7:0] MgLast = 8'(MIN_GREEN - 1);
    localparam logic [7:0] SgLast = 8'(SIDE_GREEN - 1);
    localparam logic [7:0] YlLast = 8'(YELLOW_T - 1);
    localparam logic [7:0] ArLast = 8'(ALLRED_T - 1);
    localparam logic [7:0] WkLast = 8'(WALK_T - 1);

    typedef enum logic [2:0] {
        StMainGreen  = 3'd0,
        StMainYellow = 3'd1,
        StAllRedA    = 3'd2,
        StSideGreen  = 3'd3,
        StSideYellow = 3'd4,
        StAllRedB    = 3'd5,
        StWalk       = 3'd6
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       side_pend, side_pend_d;
    logic       ped_pend, ped_pend_d;
    logic [2:0] main_d, side_d;
    logic       walk_d;
    logic       entry;

    always_comb begin
        state_d = state_q;
        case (state_q)
            StMainGreen: begin
                if (cnt_q == MgLast && (side_pend || ped_pend)) state_d = StMainYellow;
            end
            StMainYellow: if (cnt_q == YlLast) state_d = StAllRedA;
            StAllRedA: begin
                if (cnt_q == ArLast) begin
                    if (side_pend)     state_d = StSideGreen;
                    else if (ped_pend) state_d = StWalk;
                    else               state_d = StMainGreen;
                end
            end
            StSideGreen:  if (cnt_q == SgLast) state_d = StSideYellow;
            StSideYellow: if (cnt_q == YlLast) state_d = StAllRedB;
            StAllRedB: begin
                if (cnt_q == ArLast) state_d = ped_pend ? StWalk : StMainGreen;
            end
            StWalk:       if (cnt_q == WkLast) state_d = StMainGreen;
            default:      state_d = StMainGreen;
        endcase
    end

    always_comb begin
        entry = (state_d != state_q);
        if (entry) begin
            cnt_d = 8'd0;
        end else if (state_q == StMainGreen && cnt_q == MgLast) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        // A request sampled on the entry edge survives the clear and is served next round.
        side_pend_d = side_req | (side_pend & ~(entry && state_d == StSideGreen));
        ped_pend_d  = ped_req  | (ped_pend  & ~(entry && state_d == StWalk));
    end

    always_comb begin
        main_d = LampRed;
        side_d = LampRed;
        walk_d = 1'b0;
        case (state_d)
            StMainGreen:  main_d = LampGreen;
            StMainYellow: main_d = LampYellow;
            StSideGreen:  side_d = LampGreen;
            StSideYellow: side_d = LampYellow;
            StWalk:       walk_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= StMainGreen;
            cnt_q      <= 8'd0;
            side_pend  <= 1'b0;
            ped_pend   <= 1'b0;
            main_light <= LampGreen;
            side_light <= LampRed;
            walk       <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            side_pend  <= side_pend_d;
            ped_pend   <= ped_pend_d;
            main_light <= main_d;
            side_light <= side_d;
            walk       <= walk_d;
        end
    end

    assign phase = state_q;

endmodule
